// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// FSM state encoding and counter sizing helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so WIDTH=1 and powers of two fit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder used as the per-bit datapath slice.
// Ports: a, b, cin -> y (sum bit), carry (carry out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic y,
  output logic carry
);

  assign y     = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder time-shared LSB first.
// Ports: clk, rst_n, start, a, b, cin -> busy, done, sum, cout.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           st;
  logic [WIDTH-1:0] asr;
  logic [WIDTH-1:0] bsr;
  logic [WIDTH-1:0] ssr;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fy;
  logic             fc;
  logic [WIDTH-1:0] snext;
  logic             last;

  full_adder u_fa (
    .a     (asr[0]),
    .b     (bsr[0]),
    .cin   (cy),
    .y     (fy),
    .carry (fc)
  );

  // New sum bit enters at the MSB; after WIDTH shifts
  // bit 0 of the result sits at ssr[0].
  assign snext = (ssr >> 1) | (WIDTH'(fy) << (WIDTH - 1));
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      asr  <= '0;
      bsr  <= '0;
      ssr  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            asr  <= a;
            bsr  <= b;
            ssr  <= '0;
            cy   <= cin;
            cnt  <= '0;
            busy <= 1'b1;
            st   <= RUN;
          end
        end
        RUN: begin
          asr <= asr >> 1;
          bsr <= bsr >> 1;
          ssr <= snext;
          cy  <= fc;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum  <= snext;
            cout <= fc;
            busy <= 1'b0;
            done <= 1'b1;
            st   <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          st   <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl, WIDTH=8.
// Stimulus pushes expected sums; a monitor checks each done.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         cout;
  logic [W-1:0] sum;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  typedef struct {
    logic [W:0] res;
    int         due;
  } exp_t;

  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: exact (W+1)-bit sum, done W edges after accept.
  task automatic expect_add(input logic [W-1:0] x,
                            input logic [W-1:0] y,
                            input logic c, input int acc);
    exp_t e;
    e.res = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.due = acc + W;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", {24'b0, sum}, {24'b0, e.res[W-1:0]});
        chk("cout", {31'b0, cout}, {31'b0, e.res[W]});
        chk("done_time", cyc, e.due);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    expect_add(x, y, c, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("busy_end", {31'b0, busy}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_clear(input string nm);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, done}, 32'd0);
    chk({nm, "_sum"}, {24'b0, sum}, 32'd0);
    chk({nm, "_cout"}, {31'b0, cout}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc;

    // Reset with noisy inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); start = 1'($urandom);
    end
    chk_clear("reset");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    idle(20);

    // Directed cases.
    run_op(8'h35, 8'h4A, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);

    // Start during RUN is ignored; operands captured.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    acc = cyc + 1;
    expect_add(8'h10, 8'h20, 1'b0, acc);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(16);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(3);
    rst_n = 1'b0;
    #1;
    chk_clear("midreset");
    idle(3);
    rst_n = 1'b1;
    idle(20);
    run_op(8'h01, 8'h02, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'hC3; b = 8'h3C; cin = 1'b0; start = 1'b1;
    acc = cyc + 1;
    for (int i = 0; i < 4; i++)
      expect_add(8'hC3, 8'h3C, 1'b0, acc + i * (W + 2));
    idle(40);
    start = 1'b0;
    idle(12);

    // Random operands.
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    idle(4);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
